// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
//   mc_state_e   : multi-cycle unit handshake FSM state
//   slot_flags_t : per back-end slot control bits (the destination register
//                  address lives in a separate array because its width is a
//                  parameter of the controller)
//   FWD_NONE     : forwarding select value meaning "read the register file"
package pipe_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mc_state_e;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic is_load;
      logic is_mc;
   } slot_flags_t;

   localparam int FWD_NONE = 0;

endpackage

// File: rtl/fwd_select.sv
// Forwarding priority encoder for one source operand.
//   hit : per back-end slot, that slot may supply the operand (bit0 = EX)
//   sel : FWD_NONE when no hit, otherwise 1 + index of the youngest hit
module fwd_select
   import pipe_pkg::*;
#(
   parameter int NB    = 3,
   parameter int FWD_W = 2
) (
   input  logic [NB-1:0]    hit,
   output logic [FWD_W-1:0] sel
);

   // Walk from oldest to youngest so the youngest producer wins.
   always_comb begin
      sel = FWD_W'(FWD_NONE);
      for (int s = NB - 1; s >= 0; s--) begin
         if (hit[s]) sel = FWD_W'(s + 1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / interlock controller for the in-order integer pipeline.
// Tracks the back-end slots (EX..WB), produces front/back stalls, the redirect
// flush, per-operand forwarding selects and the multi-cycle unit handshake.
//   clk, reset (async, active low)
//   id_*          : decode-stage instruction description
//   ex_redirect   : taken branch/jump resolved in EX
//   cpu_halt      : stop issuing from decode
//   mc_done       : multi-cycle result valid pulse
//   mc_start      : multi-cycle start pulse
//   stall_front   : hold PC, IF/ID, ID/EX
//   stall_back    : hold EX/MEM and later
//   flush_front   : clear IF/ID and ID/EX
//   fwd_rs1/2_sel : 0 = regfile, k = result of slot k-1
//   slot_valid    : valid per back-end slot, bit0 = EX
//   mc_err        : sticky multi-cycle timeout flag
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter  int NUM_STAGES = 5,
   parameter  int REG_ADDR_W = 5,
   parameter  int LOAD_LAT   = 1,
   parameter  int MC_TIMEOUT = 64,
   localparam int NB         = NUM_STAGES - 2,
   localparam int FWD_W      = $clog2(NB + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   input  logic                  id_is_mc,
   input  logic                  ex_redirect,
   input  logic                  cpu_halt,
   input  logic                  mc_done,
   output logic                  mc_start,
   output logic                  stall_front,
   output logic                  stall_back,
   output logic                  flush_front,
   output logic [FWD_W-1:0]      fwd_rs1_sel,
   output logic [FWD_W-1:0]      fwd_rs2_sel,
   output logic [NB-1:0]         slot_valid,
   output logic                  mc_err
);

   localparam int CNT_W = $clog2(MC_TIMEOUT + 1);

   slot_flags_t [NB-1:0]                 slot_q, slot_d;
   logic        [NB-1:0][REG_ADDR_W-1:0] slot_rd_q, rd_d;

   logic [NB-1:0] m1, m2, young_ld;
   logic          load_use, flush_c, issue;

   mc_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             mc_start_c, busy_stall, timeout_hit;

   // ---------------- slot match / next-slot generation ----------------
   for (genvar s = 0; s < NB; s++) begin : g_slot
      assign m1[s] = slot_q[s].valid & slot_q[s].reg_write & (slot_rd_q[s] == id_rs1)
                   & (id_rs1 != '0) & id_use_rs1;
      assign m2[s] = slot_q[s].valid & slot_q[s].reg_write & (slot_rd_q[s] == id_rs2)
                   & (id_rs2 != '0) & id_use_rs2;
      // load data is not available yet in the first LOAD_LAT slots
      assign young_ld[s]   = slot_q[s].is_load & (s < LOAD_LAT);
      assign slot_valid[s] = slot_q[s].valid;

      if (s == 0) begin : g_head
         assign slot_d[0] = issue ? slot_flags_t'{1'b1, id_reg_write, id_is_load, id_is_mc}
                                  : slot_flags_t'('0);
         assign rd_d[0]   = issue ? id_rd : '0;
      end else begin : g_tail
         assign slot_d[s] = slot_q[s-1];
         assign rd_d[s]   = slot_rd_q[s-1];
      end
   end

   assign load_use = |((m1 | m2) & young_ld);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q    <= '0;
         slot_rd_q <= '0;
      end else if (!stall_back) begin
         slot_q    <= slot_d;
         slot_rd_q <= rd_d;
      end
   end

   // ---------------- forwarding ----------------
   fwd_select #(.NB(NB), .FWD_W(FWD_W)) u_fwd_rs1 (.hit(m1 & ~young_ld), .sel(fwd_rs1_sel));
   fwd_select #(.NB(NB), .FWD_W(FWD_W)) u_fwd_rs2 (.hit(m2 & ~young_ld), .sel(fwd_rs2_sel));

   // ---------------- multi-cycle handshake ----------------
   // The stall drops combinationally in the cycle that ends BUSY (done or the
   // final timeout cycle) so the mc op leaves EX on that edge and cannot
   // retrigger mc_start once the FSM is back in IDLE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      mc_start_c  = 1'b0;
      busy_stall  = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (slot_q[0].valid & slot_q[0].is_mc) begin
               mc_start_c = 1'b1;
               state_d    = BUSY;
               cnt_d      = '0;
            end
         end
         BUSY: begin
            timeout_hit = (cnt_q == CNT_W'(MC_TIMEOUT - 1));
            if (mc_done) begin
               state_d = IDLE;
            end else if (timeout_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               busy_stall = 1'b1;
               cnt_d      = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // ---------------- stall / flush priority ----------------
   // mc stall > redirect flush > load-use > halt; reset forces all low.
   assign stall_back  = mc_start_c | busy_stall;
   assign flush_c     = ex_redirect & ~stall_back;
   assign stall_front = reset & (stall_back | (~flush_c & (load_use | cpu_halt)));
   assign flush_front = reset & flush_c;
   assign issue       = id_valid & ~stall_front & ~flush_front & ~cpu_halt;
   assign mc_start    = mc_start_c;
   assign mc_err      = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: the driver applies one cycle of inputs and queues the
// hand-computed outputs for that cycle; a monitor on the falling edge pops
// and compares. Instance 0 uses MC_TIMEOUT=64, instance 1 MC_TIMEOUT=8.
module tb_pipe_hazard_ctrl;

   logic       clk, reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, id_is_mc;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_redirect, cpu_halt, mc_done;

   logic [1:0]      ms, sf, sb, ff, me;
   logic [1:0][1:0] f1, f2;
   logic [1:0][2:0] sv;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string      nm;
      logic       ms, sf, sb, ff;
      logic [1:0] f1, f2;
      logic [2:0] sv;
      logic       me;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .LOAD_LAT(1), .MC_TIMEOUT(64)) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
      .ex_redirect(ex_redirect), .cpu_halt(cpu_halt), .mc_done(mc_done),
      .mc_start(ms[0]), .stall_front(sf[0]), .stall_back(sb[0]), .flush_front(ff[0]),
      .fwd_rs1_sel(f1[0]), .fwd_rs2_sel(f2[0]), .slot_valid(sv[0]), .mc_err(me[0]));

   pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .LOAD_LAT(1), .MC_TIMEOUT(8)) u_to (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
      .ex_redirect(ex_redirect), .cpu_halt(cpu_halt), .mc_done(mc_done),
      .mc_start(ms[1]), .stall_front(sf[1]), .stall_back(sb[1]), .flush_front(ff[1]),
      .fwd_rs1_sel(f1[1]), .fwd_rs2_sel(f2[1]), .slot_valid(sv[1]), .mc_err(me[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
      end
   endtask

   task automatic check(input int d, input exp_t e);
      cmp(e.nm, "mc_start",    8'(ms[d]), 8'(e.ms));
      cmp(e.nm, "stall_front", 8'(sf[d]), 8'(e.sf));
      cmp(e.nm, "stall_back",  8'(sb[d]), 8'(e.sb));
      cmp(e.nm, "flush_front", 8'(ff[d]), 8'(e.ff));
      cmp(e.nm, "fwd_rs1_sel", 8'(f1[d]), 8'(e.f1));
      cmp(e.nm, "fwd_rs2_sel", 8'(f2[d]), 8'(e.f2));
      cmp(e.nm, "slot_valid",  8'(sv[d]), 8'(e.sv));
      cmp(e.nm, "mc_err",      8'(me[d]), 8'(e.me));
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) check(0, q0.pop_front());
      if (q1.size() > 0) check(1, q1.pop_front());
   end

   // ---------------- stimulus ----------------
   task automatic ex(input string nm, input int d, input logic e_ms, e_sf, e_sb, e_ff,
                     input logic [1:0] e_f1, e_f2, input logic [2:0] e_sv, input logic e_me);
      exp_t e;
      e.nm = nm; e.ms = e_ms; e.sf = e_sf; e.sb = e_sb; e.ff = e_ff;
      e.f1 = e_f1; e.f2 = e_f2; e.sv = e_sv; e.me = e_me;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw, input logic ld, input logic mc);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_is_load = ld; id_is_mc = mc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      // reset: outputs low even with halt/redirect/operands active
      reset = 1'b0; cpu_halt = 1'b1; ex_redirect = 1'b1; mc_done = 1'b1;
      id_set(1, 5, 1, 3, 1, 6, 1, 1, 0);
      @(posedge clk); #1;
      ex("reset", 0, 0,0,0,0, 0,0, 3'b000, 0);
      reset = 1'b1; cpu_halt = 1'b0; ex_redirect = 1'b0; mc_done = 1'b0;

      // load-use: lw x5 ; add x6,x5,x1
      id_set(1, 1, 1, 0, 0, 5, 1, 1, 0); ex("lu_issue", 0, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(1, 5, 1, 1, 1, 6, 1, 0, 0); ex("lu_stall", 0, 0,1,0,0, 0,0, 3'b001, 0);
      ex("lu_fwd", 0, 0,0,0,0, 2,0, 3'b010, 0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); ex("lu_drain", 0, 0,0,0,0, 0,0, 3'b101, 0);
      tick(2);

      // ALU forwarding and x0 handling
      id_set(1, 1, 1, 2, 1, 3, 1, 0, 0); ex("fw_add",    0, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(1, 3, 1, 3, 1, 4, 1, 0, 0); ex("fw_sub",    0, 0,0,0,0, 1,1, 3'b001, 0);
      id_set(1, 3, 1, 4, 1, 5, 1, 0, 0); ex("fw_two",    0, 0,0,0,0, 2,1, 3'b011, 0);
      id_set(1, 1, 1, 1, 1, 0, 1, 0, 0); ex("fw_wr_x0",  0, 0,0,0,0, 0,0, 3'b111, 0);
      id_set(1, 0, 1, 0, 1, 7, 1, 0, 0); ex("fw_rd_x0",  0, 0,0,0,0, 0,0, 3'b111, 0);
      id_set(1, 7, 0, 5, 1, 0, 0, 0, 0); ex("fw_unused", 0, 0,0,0,0, 0,3, 3'b111, 0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(3);

      // redirect flush and halt
      id_set(1, 1, 1, 0, 0, 9, 1, 0, 0); ex("rd_pre", 0, 0,0,0,0, 0,0, 3'b000, 0);
      ex_redirect = 1'b1;
      id_set(1, 9, 1, 0, 0, 8, 1, 0, 0); ex("rd_flush", 0, 0,0,0,1, 1,0, 3'b001, 0);
      ex_redirect = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); ex("rd_bubble", 0, 0,0,0,0, 0,0, 3'b010, 0);
      cpu_halt = 1'b1; ex_redirect = 1'b1;
      id_set(1, 0, 0, 0, 0, 8, 1, 0, 0); ex("halt_flush", 0, 0,0,0,1, 0,0, 3'b100, 0);
      ex_redirect = 1'b0; ex("halt", 0, 0,1,0,0, 0,0, 3'b000, 0);
      cpu_halt = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); ex("halt_bubble", 0, 0,0,0,0, 0,0, 3'b000, 0);

      // div: done after 33 BUSY cycles
      id_set(1, 0, 0, 0, 0, 10, 1, 0, 1); ex("div_issue", 0, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);  ex("div_start", 0, 1,1,1,0, 0,0, 3'b001, 0);
      for (int i = 1; i <= 33; i++) begin
         ex_redirect = (i == 5);
         ex($sformatf("div_busy%0d", i), 0, 0,1,1,0, 0,0, 3'b001, 0);
      end
      ex_redirect = 1'b0; mc_done = 1'b1;
      ex("div_done", 0, 0,0,0,0, 0,0, 3'b001, 0);
      ex("done_in_idle", 0, 0,0,0,0, 0,0, 3'b010, 0);
      mc_done = 1'b0; tick(2);

      // reset mid-BUSY
      id_set(1, 0, 0, 0, 0, 11, 1, 0, 1); ex("rst_div_issue", 0, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);  ex("rst_div_start", 0, 1,1,1,0, 0,0, 3'b001, 0);
      ex("rst_div_busy", 0, 0,1,1,0, 0,0, 3'b001, 0);
      reset = 1'b0; cpu_halt = 1'b1; ex_redirect = 1'b1; mc_done = 1'b1;
      id_set(1, 3, 1, 4, 1, 5, 1, 1, 0);
      ex("rst_async", 0, 0,0,0,0, 0,0, 3'b000, 0);
      reset = 1'b1; cpu_halt = 1'b0; ex_redirect = 1'b0; mc_done = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);  ex("rst_after", 0, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(1, 0, 0, 0, 0, 12, 1, 0, 1); ex("rst_div2_issue", 0, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);  ex("rst_div2_start", 0, 1,1,1,0, 0,0, 3'b001, 0);
      mc_done = 1'b1; ex("rst_div2_done", 0, 0,0,0,0, 0,0, 3'b001, 0);
      mc_done = 1'b0; tick(3);

      // timeout on the MC_TIMEOUT=8 instance
      id_set(1, 0, 0, 0, 0, 13, 1, 0, 1); ex("to_issue", 1, 0,0,0,0, 0,0, 3'b000, 0);
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);  ex("to_start", 1, 1,1,1,0, 0,0, 3'b001, 0);
      for (int i = 1; i <= 7; i++) ex($sformatf("to_busy%0d", i), 1, 0,1,1,0, 0,0, 3'b001, 0);
      ex("to_last", 1, 0,0,0,0, 0,0, 3'b001, 0);
      ex("to_err", 1, 0,0,0,0, 0,0, 3'b010, 1);
      mc_done = 1'b1; ex("to_err_done", 1, 0,0,0,0, 0,0, 3'b100, 1);
      mc_done = 1'b0; ex("to_err_sticky", 1, 0,0,0,0, 0,0, 3'b000, 1);

      tick(2);
      n_chk++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
